// File: rtl/mul_div_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit and its control unit.
package mul_div_pkg;

    localparam int unsigned MdWidth = 32;
    localparam int unsigned MdIter  = MdWidth;
    localparam int unsigned MdCntW  = $clog2(MdIter);

    // ALU opcodes handled here rather than by the combinational ALU
    localparam logic [3:0] OpMul = 4'b1000;
    localparam logic [3:0] OpDiv = 4'b1001;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } md_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_restore_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;
    logic           unused_diff_msb;

    // Shift {R,Q} left by one, trial-subtract the divisor and keep it only if non-negative.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        fits     = (shifted >= {1'b0, divisor});
        // Both branches are below the divisor, so the top bit is always zero here
        rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

    assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/mul_div_32.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit with start/done handshake.
module mul_div_32
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH = MdWidth,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic             in_clk,
    input  logic             in_reset,
    input  logic             in_start,
    input  logic             in_div,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo
);

    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_e        state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] hi_q;     // Booth HI / division remainder
    logic [WIDTH-1:0] lo_q;     // Booth LO / division quotient
    logic             qm1_q;    // Booth q-1 bit
    logic [WIDTH-1:0] b_q;      // multiplier, or divisor magnitude
    logic             div_q;
    logic             a_neg_q;
    logic             b_neg_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   hi_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // Operand magnitudes for division; -2^(W-1) maps onto itself, which is correct unsigned.
    always_comb begin
        a_mag = in_a[WIDTH-1] ? (~in_a + 1'b1) : in_a;
        b_mag = in_b[WIDTH-1] ? (~in_b + 1'b1) : in_b;
    end

    // Booth add/subtract on sign-extended operands so subtracting the most negative value works.
    always_comb begin
        hi_ext = {hi_q[WIDTH-1], hi_q};
        b_ext  = {b_q[WIDTH-1], b_q};
        unique case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = hi_ext + b_ext;
            2'b10:   booth_sum = hi_ext - b_ext;
            default: booth_sum = hi_ext;
        endcase
    end

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (hi_q),
        .quo      (lo_q),
        .divisor  (b_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            b_q      <= '0;
            div_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            out_busy <= 1'b0;
            out_done <= 1'b0;
            out_hi   <= '0;
            out_lo   <= '0;
        end else begin
            out_done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (in_start) begin
                        div_q   <= in_div;
                        a_neg_q <= in_a[WIDTH-1];
                        b_neg_q <= in_b[WIDTH-1];
                        cnt_q   <= CntW'(ITER - 1);
                        hi_q    <= '0;
                        qm1_q   <= 1'b0;
                        lo_q    <= in_div ? a_mag : in_a;
                        b_q     <= in_div ? b_mag : in_b;
                        if (in_div && (in_b == '0)) begin
                            // Divide by zero skips the iterations entirely
                            state_q  <= StDone;
                            out_done <= 1'b1;
                            out_hi   <= in_a;
                            out_lo   <= '1;
                        end else begin
                            state_q  <= StCalc;
                            out_busy <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StCalc: begin
                    if (div_q) begin
                        hi_q <= rem_next;
                        lo_q <= quo_next;
                    end else begin
                        // Arithmetic right shift of {sum, LO, q-1}
                        hi_q  <= booth_sum[WIDTH:1];
                        lo_q  <= {booth_sum[0], lo_q[WIDTH-1:1]};
                        qm1_q <= lo_q[0];
                    end
                    if (cnt_q == '0) begin
                        state_q <= StFix;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StFix: begin
                    if (div_q) begin
                        // Quotient truncates toward zero; remainder takes the dividend's sign
                        out_lo <= (a_neg_q ^ b_neg_q) ? (~lo_q + 1'b1) : lo_q;
                        out_hi <= a_neg_q ? (~hi_q + 1'b1) : hi_q;
                    end else begin
                        out_lo <= lo_q;
                        out_hi <= hi_q;
                    end
                    out_busy <= 1'b0;
                    out_done <= 1'b1;
                    state_q  <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
